// File: rtl/ahb_arb_pkg.sv
// ahb_arb_pkg: shared state type, index-width helper and idle-bus constants for ahb_arbiter
package ahb_arb_pkg;
  typedef enum logic [1:0] {IDLE, OWNED, LOCKED} arb_state_e;
  localparam int DEF_MASTER = 0;
  localparam logic DEF_MASTLOCK = 1'b0;
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/arb_pick.sv
// arb_pick: one-hot first requester at or after start (wrapping), excluded masters masked out
module arb_pick
  import ahb_arb_pkg::*;
#(
  parameter int N = 3,
  parameter int IW = idx_w(N)
) (
  input  logic [N-1:0]  req,
  input  logic [N-1:0]  excl,
  input  logic [IW-1:0] start,
  output logic [N-1:0]  win,
  output logic          valid
);
  logic [N-1:0] m;
  assign m = req & ~excl;
  always_comb begin
    win = '0;
    valid = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (!valid && m[(int'(start) + i) % N]) begin
        win[(int'(start) + i) % N] = 1'b1;
        valid = 1'b1;
      end
    end
  end
endmodule

// File: rtl/ahb_arbiter.sv
// ahb_arbiter: AHB bus arbiter with hold-limited unlocked tenure and unpreemptable locked tenure.
// Define AHB_ARB_RR_EN for round-robin priority; otherwise the lowest requesting index wins.
module ahb_arbiter
  import ahb_arb_pkg::*;
#(
  parameter int NUM_MASTERS = 3,
  parameter int MAX_HOLD = 16,
  parameter int DEFAULT_MASTER = DEF_MASTER
) (
  input  logic                             HCLK,
  input  logic                             HRESET,
  input  logic [NUM_MASTERS-1:0]           HBUSREQ,
  input  logic [NUM_MASTERS-1:0]           HLOCK,
  input  logic                             HREADY,
  output logic [NUM_MASTERS-1:0]           HGRANT,
  output logic [idx_w(NUM_MASTERS)-1:0]    HMASTER,
  output logic                             HMASTLOCK
);
  localparam int IW = idx_w(NUM_MASTERS);
  localparam int CW = idx_w(MAX_HOLD);
  arb_state_e state_q, state_d;
  logic [NUM_MASTERS-1:0] grant_q, grant_d, req, excl, win;
  logic [IW-1:0] owner_q, owner_d, hmaster_q, hmaster_d, win_idx, start;
  logic [CW-1:0] cnt_q, cnt_d;
  logic hmastlock_q, hmastlock_d, win_v, sat, do_arb;
  // a locked master counts as requesting even with HBUSREQ low
  assign req = HBUSREQ | HLOCK;
  assign sat = cnt_q == CW'(MAX_HOLD - 1);
  assign excl = (state_q == OWNED && sat) ? grant_q : '0;
  arb_pick #(.N(NUM_MASTERS), .IW(IW)) u_pick (
    .req(req),
    .excl(excl),
    .start(start),
    .win(win),
    .valid(win_v)
  );
  always_comb begin
    win_idx = '0;
    for (int i = 0; i < NUM_MASTERS; i++) if (win[i]) win_idx = IW'(i);
  end
`ifdef AHB_ARB_RR_EN
  logic [IW-1:0] ptr_q, ptr_d;
  always_comb ptr_d = (do_arb && win_v) ? ((win_idx == IW'(NUM_MASTERS - 1)) ? '0 : win_idx + IW'(1)) : ptr_q;
  always_ff @(posedge HCLK) ptr_q <= HRESET ? '0 : ptr_d;
  assign start = ptr_q;
`else
  assign start = '0;
`endif
  always_comb begin
    do_arb = 1'b0;
    state_d = state_q;
    grant_d = grant_q;
    owner_d = owner_q;
    cnt_d = cnt_q;
    hmaster_d = hmaster_q;
    hmastlock_d = hmastlock_q;
    if (HREADY) begin
      hmaster_d = (state_q == IDLE) ? IW'(DEFAULT_MASTER) : owner_q;
      hmastlock_d = (state_q == IDLE) ? DEF_MASTLOCK : HLOCK[owner_q];
      if (state_q == IDLE || (state_q == LOCKED && !HLOCK[owner_q])) do_arb = 1'b1;
      else if (state_q == OWNED) begin
        if (HLOCK[owner_q]) state_d = LOCKED;
        else if (!req[owner_q] || (sat && |(req & ~grant_q))) do_arb = 1'b1;
        else cnt_d = sat ? cnt_q : cnt_q + CW'(1);
      end
      if (do_arb) begin
        grant_d = win;
        owner_d = win_idx;
        cnt_d = '0;
        state_d = !win_v ? IDLE : HLOCK[win_idx] ? LOCKED : OWNED;
      end
    end
  end
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state_q <= IDLE;
      grant_q <= '0;
      owner_q <= '0;
      cnt_q <= '0;
      hmaster_q <= IW'(DEFAULT_MASTER);
      hmastlock_q <= DEF_MASTLOCK;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      owner_q <= owner_d;
      cnt_q <= cnt_d;
      hmaster_q <= hmaster_d;
      hmastlock_q <= hmastlock_d;
    end
  end
  assign HGRANT = grant_q;
  assign HMASTER = hmaster_q;
  assign HMASTLOCK = hmastlock_q;
endmodule

// File: tb/tb_ahb_arbiter.sv
// tb_ahb_arbiter: directed scenarios plus sticky random traffic against a behavioural arbiter model
module tb_ahb_arbiter;
  localparam int NM = 3;
  localparam int MH = 16;
  logic HCLK, HRESET, HREADY, HMASTLOCK;
  logic [NM-1:0] HBUSREQ, HLOCK, HGRANT;
  logic [1:0] HMASTER;
  int n_tests = 0;
  int n_fail = 0;
  int m_own, m_held, m_ptr, m_hm;
  bit m_lk, m_hml;
  logic [2:0] br, lk;
`ifdef AHB_ARB_RR_EN
  int order[4] = '{0, 1, 2, 0};
`else
  int order[4] = '{0, 1, 0, 1};
`endif
  ahb_arbiter #(.NUM_MASTERS(NM), .MAX_HOLD(MH), .DEFAULT_MASTER(0)) dut (
    .HCLK(HCLK),
    .HRESET(HRESET),
    .HBUSREQ(HBUSREQ),
    .HLOCK(HLOCK),
    .HREADY(HREADY),
    .HGRANT(HGRANT),
    .HMASTER(HMASTER),
    .HMASTLOCK(HMASTLOCK)
  );
  initial begin
    HCLK = 0;
    forever #5 HCLK = ~HCLK;
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  function automatic int pick(input logic [2:0] m, input int s);
    for (int i = 0; i < NM; i++) if (m[(s + i) % NM]) return (s + i) % NM;
    return -1;
  endfunction
  function automatic logic [2:0] exp_grant();
    return (m_own < 0) ? 3'b000 : 3'(1 << m_own);
  endfunction
  // model: owner index (-1 = none), tenure length in ready cycles, lock mode
  task automatic model_step(input logic [2:0] b, input logic [2:0] l, input logic r, input logic rs);
    logic [2:0] want, others;
    int nhm;
    bit nhml, arb;
    if (rs) begin
      m_own = -1;
      m_lk = 0;
      m_held = 0;
      m_ptr = 0;
      m_hm = 0;
      m_hml = 0;
      return;
    end
    if (!r) return;
    want = b | l;
    nhm = (m_own < 0) ? 0 : m_own;
    nhml = (m_own >= 0) && l[m_own];
    arb = 0;
    others = want;
    if (m_own < 0) arb = 1;
    else if (m_lk) arb = !l[m_own];
    else if (l[m_own]) m_lk = 1;
    else if (!want[m_own]) arb = 1;
    else if (m_held >= MH - 1 && (want & ~exp_grant()) != 0) begin
      arb = 1;
      others = want & ~exp_grant();
    end else m_held++;
    if (arb) begin
      m_own = pick(others, m_ptr);
      m_lk = (m_own >= 0) && l[m_own];
      m_held = 0;
`ifdef AHB_ARB_RR_EN
      if (m_own >= 0) m_ptr = (m_own + 1) % NM;
`endif
    end
    m_hm = nhm;
    m_hml = nhml;
  endtask
  task automatic cyc(input logic [2:0] b, input logic [2:0] l, input logic r, input logic rs);
    HBUSREQ = b;
    HLOCK = l;
    HREADY = r;
    HRESET = rs;
    @(posedge HCLK);
    model_step(b, l, r, rs);
    @(negedge HCLK);
    check("model_grant", HGRANT, exp_grant());
    check("model_hmaster", HMASTER, m_hm);
    check("model_hmastlock", HMASTLOCK, m_hml);
    check("onehot", $onehot0(HGRANT), 1);
  endtask
  initial begin
    cyc(0, 0, 1, 1);
    check("rst_grant", HGRANT, 0);
    check("rst_hmaster", HMASTER, 0);
    check("rst_mastlock", HMASTLOCK, 0);
    cyc(3'b011, 0, 1, 0);
    check("first_grant", HGRANT, 3'b001);
    cyc(3'b011, 0, 1, 0);
    check("first_hmaster", HMASTER, 0);
    cyc(0, 0, 1, 1);
    cyc(3'b010, 3'b010, 1, 0);
    for (int i = 0; i < 40; i++) begin
      cyc(3'b011, 3'b010, 1, 0);
      check("lock_grant", HGRANT, 3'b010);
      check("lock_mastlock", HMASTLOCK, 1);
    end
    cyc(3'b011, 0, 1, 0);
    check("unlock_grant", HGRANT, 3'b001);
    cyc(0, 0, 1, 1);
    cyc(3'b100, 0, 1, 0);
    check("hold_start", HGRANT, 3'b100);
    for (int i = 1; i <= 16; i++) begin
      cyc(3'b101, 0, 1, 0);
      check("hold_grant", HGRANT, (i < 16) ? 32'h4 : 32'h1);
    end
    cyc(0, 0, 1, 1);
    cyc(3'b001, 0, 1, 0);
    cyc(3'b001, 0, 1, 0);
    repeat (5) begin
      cyc(3'b010, 0, 0, 0);
      check("frz_grant", HGRANT, 3'b001);
      check("frz_hmaster", HMASTER, 0);
    end
    cyc(3'b010, 0, 1, 0);
    check("hand_grant", HGRANT, 3'b010);
    check("hand_hmaster", HMASTER, 0);
    repeat (5) begin
      cyc(3'b010, 0, 0, 0);
      check("frz2_hmaster", HMASTER, 0);
    end
    cyc(3'b010, 0, 1, 0);
    check("hand2_hmaster", HMASTER, 1);
    cyc(0, 0, 1, 1);
    cyc(3'b010, 3'b010, 1, 0);
    cyc(3'b010, 3'b010, 1, 0);
    check("lk_mastlock", HMASTLOCK, 1);
    cyc(3'b010, 3'b010, 0, 1);
    check("rstlk_grant", HGRANT, 0);
    check("rstlk_hmaster", HMASTER, 0);
    check("rstlk_mastlock", HMASTLOCK, 0);
    cyc(3'b010, 3'b010, 1, 0);
    cyc(3'b010, 0, 1, 0);
    check("regrant", HGRANT, 3'b010);
    cyc(0, 0, 1, 1);
    for (int i = 0; i < 4; i++) begin
      cyc(3'b111 & ~exp_grant(), 0, 1, 0);
      check("order", HGRANT, 32'(1 << order[i]));
    end
    br = 0;
    lk = 0;
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 31) == 0) br = 3'($urandom);
      if ($urandom_range(0, 31) == 0) lk = 3'($urandom) & 3'($urandom);
      cyc(br, lk, $urandom_range(0, 4) != 0, $urandom_range(0, 199) == 0);
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
